// File: rtl/iter_multdiv.sv
// Sequential signed multiplier/divider for the execute stage.
// Multiply is a shift-add over WIDTH iterations on a double-width product.
// Divide is restoring division on operand magnitudes with a final sign fix-up.
// The block produces one quotient or product bit per clock edge.
module iter_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH:0]   MIN_MAG = {2'b01, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q;     // running signed product
  logic [2*WIDTH-1:0] mcand_q;    // sign-extended multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q;   // multiplier, shifted right each step
  logic [2*WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0]   dvd_q;      // dividend magnitude; quotient bits shift in at the bottom
  logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
  logic               neg_q;      // quotient must be negated
  logic               div0_q;     // divisor was zero
  logic               ovf_q;      // most-negative / -1 case
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;

  logic               start;
  logic               last_iter;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     b_ext;
  logic [WIDTH:0]     mag_a;
  logic [WIDTH:0]     mag_b;
  logic               start_div0;
  logic               start_ovf;
  logic [2*WIDTH-1:0] add_term;
  logic [2*WIDTH-1:0] prod_d;
  logic               mul_ovf;
  logic [2*WIDTH:0]   shifted;
  logic [2*WIDTH:0]   trial;
  logic               q_bit;
  logic [2*WIDTH-1:0] rem_d;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   div_res;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Operand magnitudes use one extra bit so negating the most-negative value cannot overflow.
  always_comb begin
    a_ext      = {data_operandA[WIDTH-1], data_operandA};
    b_ext      = {data_operandB[WIDTH-1], data_operandB};
    mag_a      = data_operandA[WIDTH-1] ? (~a_ext + (WIDTH+1)'(1)) : a_ext;
    mag_b      = data_operandB[WIDTH-1] ? (~b_ext + (WIDTH+1)'(1)) : b_ext;
    start_div0 = (mag_b == '0);
    start_ovf  = (mag_a == MIN_MAG) && (data_operandB == '1);
  end

  // One shift-add step; the multiplier's sign bit carries negative weight, so the last step subtracts.
  always_comb begin
    add_term = mplier_q[0] ? mcand_q : '0;
    prod_d   = last_iter ? (prod_q - add_term) : (prod_q + add_term);
    mul_ovf  = !((&prod_d[2*WIDTH-1:WIDTH-1]) || !(|prod_d[2*WIDTH-1:WIDTH-1]));
  end

  // One restoring-division step; the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {{(WIDTH+1){1'b0}}, dvs_q};
    q_bit   = ~trial[2*WIDTH];
    rem_d   = q_bit ? trial[2*WIDTH-1:0] : shifted[2*WIDTH-1:0];
    q_mag   = {dvd_q[WIDTH-2:0], q_bit};
    if (div0_q) begin
      div_res = '0;
    end else if (ovf_q) begin
      div_res = MIN_VAL;
    end else begin
      div_res = neg_q ? (~q_mag + WIDTH'(1)) : q_mag;
    end
  end

  // Control FSM and datapath registers; a start pulse always wins and restarts the operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (start) begin
      state_q  <= ctrl_MULT ? MUL : DIV;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
      mplier_q <= data_operandB;
      rem_q    <= '0;
      dvd_q    <= mag_a[WIDTH-1:0];
      dvs_q    <= mag_b[WIDTH-1:0];
      neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div0_q   <= start_div0;
      ovf_q    <= start_ovf;
    end else begin
      case (state_q)
        MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_iter) begin
            state_q  <= DONE;
            result_q <= prod_d[WIDTH-1:0];
            exc_q    <= mul_ovf;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          dvd_q <= q_mag;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            state_q  <= DONE;
            result_q <= div_res;
            exc_q    <= div0_q | ovf_q;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == MUL) || (state_q == DIV);

endmodule

// File: tb/tb_iter_multdiv.sv
// Directed bench for iter_multdiv: multiply, divide, exceptions, restart and async reset.
module tb_iter_multdiv;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  iter_multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start pulse; returns at the falling edge right after the start edge.
  task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
  endtask

  // Follow an operation from the cycle after its start edge to its RDY pulse and one cycle beyond.
  task automatic finish_op(input string tag, input logic [31:0] exp_res, input logic exp_exc,
                           input logic [31:0] prev_res);
    int k = 0;
    int busy_cycles = 0;
    while (!data_resultRDY && k < 100) begin
      if (busy) busy_cycles++;
      if (k == 16) chk({tag, "_hold"}, data_result, prev_res);
      @(negedge clock);
      k++;
    end
    chk({tag, "_latency"}, k, 32);
    chk({tag, "_busycycles"}, busy_cycles, 32);
    chk({tag, "_result"}, data_result, exp_res);
    chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    chk({tag, "_busy_at_rdy"}, {31'd0, busy}, 32'd0);
    @(negedge clock);
    chk({tag, "_rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
    $display("op %s result=%h exc=%0d latency=%0d", tag, data_result, data_exception, k);
  endtask

  initial begin
    int rdy_seen;
    reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;

    // Reset state
    @(negedge clock);
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    $display("reset state checked");
    reset = 1'b1;

    // Multiply
    pulse(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    finish_op("mul_7x-3", 32'hFFFFFFEB, 1'b0, 32'd0);
    pulse(1'b1, 1'b0, 32'h00010000, 32'h00010000);
    finish_op("mul_ovf", 32'h00000000, 1'b1, 32'hFFFFFFEB);
    pulse(1'b1, 1'b0, 32'h7FFFFFFF, 32'd1);
    finish_op("mul_max", 32'h7FFFFFFF, 1'b0, 32'h00000000);
    pulse(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    finish_op("mul_minx-1", 32'h80000000, 1'b1, 32'h7FFFFFFF);

    // Divide
    pulse(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7);
    finish_op("div_-100/7", 32'hFFFFFFF2, 1'b0, 32'h80000000);
    pulse(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9);
    finish_op("div_100/-7", 32'hFFFFFFF2, 1'b0, 32'hFFFFFFF2);
    pulse(1'b0, 1'b1, 32'd6, 32'd3);
    finish_op("div_6/3", 32'd2, 1'b0, 32'hFFFFFFF2);
    pulse(1'b0, 1'b1, 32'd5, 32'd0);
    finish_op("div_by0", 32'd0, 1'b1, 32'd2);
    pulse(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    finish_op("div_min/-1", 32'h80000000, 1'b1, 32'd0);
    pulse(1'b0, 1'b1, 32'h80000000, 32'd1);
    finish_op("div_min/1", 32'h80000000, 1'b0, 32'h80000000);

    // Restart: a DIV start while the MULT is iterating aborts it
    pulse(1'b1, 1'b0, 32'd3, 32'd4);
    rdy_seen = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    chk("restart_hold", data_result, 32'h80000000);
    pulse(1'b0, 1'b1, 32'd20, 32'd5);
    chk("restart_no_rdy", rdy_seen, 0);
    finish_op("restart_div", 32'd4, 1'b0, 32'h80000000);

    // Both starts together: multiply wins
    pulse(1'b1, 1'b1, 32'd6, 32'd2);
    finish_op("both_start", 32'd12, 1'b0, 32'd4);

    // Asynchronous reset mid-divide
    pulse(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_result", data_result, 32'd0);
    chk("arst_exc", {31'd0, data_exception}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY || busy) rdy_seen++;
    end
    chk("arst_no_resume", rdy_seen, 0);
    $display("async reset mid-divide checked");
    pulse(1'b1, 1'b0, 32'd2, 32'd2);
    finish_op("post_rst_mul", 32'd4, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
